// File: rtl/imem_loader.sv
// Program-load front end: receives a framed byte stream, writes little-endian
// 32-bit words into instruction memory and releases the core once the checksum matches.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  output logic              core_run_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  // state   | meaning
  // IDLE    | waiting for first start after reset
  // LEN_LO  | expecting low byte of word count
  // LEN_HI  | expecting high byte of word count
  // DATA    | receiving payload bytes, writing each completed word
  // CHECK   | expecting checksum byte
  // DONE    | image verified, core running
  // ERROR   | oversize image or checksum mismatch, core held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;

  assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign busy_o       = byte_ready_o;
  assign error_o      = (state_q == S_ERROR);
  assign core_run_o   = (state_q == S_DONE);
  assign core_reset_o = (state_q != S_DONE);

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign words_loaded_o = words_q;

  assign xfer      = byte_valid_i & byte_ready_o;
  assign len_full  = {byte_data_i, len_q[7:0]};
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_LO;
          words_d = '0;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if ({1'b0, len_full} > 17'(MAX_WORDS)) state_d = S_ERROR;
          else if (len_full == 16'd0)           state_d = S_CHECK;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_data_i;
          cnt_d  = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              // Fourth byte completes the word; the strobe lands next cycle
              // while the stream keeps flowing.
              we_d    = 1'b1;
              addr_d  = words_q[ADDR_W-1:0];
              wdata_d = {byte_data_i, asm_q};
              words_d = words_inc;
              if (17'(words_inc) == {1'b0, len_q}) state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: frames are built from word
// lists, and every write and status output is compared with the expected image.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              reset, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, imem_we, core_reset, core_run, busy, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0]       exp_words[$];
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .core_reset_o(core_reset), .core_run_o(core_run), .busy_o(busy),
    .error_o(error), .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  // Frame = 16-bit little-endian count, payload bytes LSB first, XOR checksum.
  task automatic build_frame(input bit bad_csum);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] n;
    frame.delete();
    cs = 8'h00;
    n  = 16'(exp_words.size());
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (exp_words[i])
      for (int k = 0; k < 4; k++) begin
        b = 8'((exp_words[i] >> (8 * k)) & 32'hFF);
        frame.push_back(b);
        cs = cs ^ b;
      end
    frame.push_back(bad_csum ? (cs ^ 8'h01) : cs);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_bytes(input int first, input int last, input int gap_pct, input int start_at);
    int waited;
    for (int i = first; i <= last; i++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        @(negedge clk); byte_valid = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      start      = (i == start_at);
      byte_valid = 1'b1;
      byte_data  = frame[i];
      waited     = 0;
      while (!byte_ready && waited < 50) begin
        @(negedge clk); waited++;
      end
      if (waited >= 50) begin
        checks++; failures++;
        $display("FAIL handshake_timeout byte=%0d byte_ready=%b required=1", i, byte_ready);
        byte_valid = 1'b0; start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_load(input string name, input bit exp_err);
    int n;
    n = exp_words.size();
    checks++;
    if (got_addr.size() !== n) begin
      failures++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, got_addr.size(), n);
    end
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_words[i]) begin
        failures++;
        $display("FAIL %s write%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 name, i, got_addr[i], got_data[i], i, exp_words[i]);
      end
    end
    checks++;
    if (words_loaded !== (ADDR_W+1)'(n)) begin
      failures++;
      $display("FAIL %s words_loaded got=%0d exp=%0d", name, words_loaded, n);
    end
    checks++;
    if ({error, core_reset, core_run, busy, byte_ready} !== {exp_err, exp_err, !exp_err, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s status got err/rst/run/busy/rdy=%b%b%b%b%b exp=%b%b%b00",
               name, error, core_reset, core_run, busy, byte_ready, exp_err, exp_err, !exp_err);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({byte_ready, imem_we, core_reset, core_run, busy, error} !== 6'b001000 ||
        imem_addr !== '0 || imem_wdata !== '0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL %s got rdy/we/rst/run/busy/err=%b%b%b%b%b%b addr=%0d wdata=%h words=%0d exp 001000 0 0 0",
               name, byte_ready, imem_we, core_reset, core_run, busy, error, imem_addr, imem_wdata, words_loaded);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset_state");
  endtask

  task automatic test_basic();
    exp_words = '{32'h00500093, 32'h00A00113};
    build_frame(1'b0);
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, frame.size() - 2, 0, -1);
    checks++;
    if (core_reset !== 1'b1 || core_run !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_pre_checksum got rst=%b run=%b busy=%b exp 1 0 1", core_reset, core_run, busy);
    end
    drive_bytes(frame.size() - 1, frame.size() - 1, 0, -1);
    check_load("basic", 1'b0);
  endtask

  task automatic test_bad_checksum();
    exp_words = '{32'h00500093, 32'h00A00113};
    build_frame(1'b1);
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, frame.size() - 1, 0, -1);
    check_load("bad_checksum", 1'b1);
  endtask

  task automatic test_too_long();
    frame = '{8'h01, 8'h01, 8'hAA};
    exp_words.delete();
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, 1, 0, -1);
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || byte_ready !== 1'b0 || core_reset !== 1'b1 || got_addr.size() !== 0) begin
      failures++;
      $display("FAIL too_long got err=%b rdy=%b rst=%b writes=%0d exp 1 0 1 0",
               error, byte_ready, core_reset, got_addr.size());
    end
  endtask

  task automatic test_zero_len();
    exp_words.delete();
    build_frame(1'b0);
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, frame.size() - 1, 0, -1);
    check_load("zero_len", 1'b0);
  endtask

  task automatic test_random_gaps();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(12, 1);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      build_frame(1'b0);
      got_addr.delete(); got_data.delete();
      pulse_start();
      drive_bytes(0, frame.size() - 1, 40, $urandom_range(frame.size() - 2, 1));
      check_load($sformatf("random_gaps%0d", it), 1'b0);
    end
  endtask

  task automatic test_max_len();
    exp_words.delete();
    for (int i = 0; i < MAX_WORDS; i++) exp_words.push_back($urandom);
    build_frame(1'b0);
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, frame.size() - 1, 0, -1);
    check_load("max_len", 1'b0);
  endtask

  task automatic test_reset_midload();
    exp_words = '{32'hDEADBEEF, 32'h12345678};
    build_frame(1'b0);
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, 6, 0, -1);
    reset = 1'b1;
    #1;
    check_reset_values("reset_midload");
    checks++;
    if (got_addr.size() !== 1) begin
      failures++;
      $display("FAIL reset_midload_partial writes got=%0d exp=1", got_addr.size());
    end
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (got_addr.size() !== 1 || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL reset_midload_quiet got writes=%0d rst=%b exp 1 1", got_addr.size(), core_reset);
    end
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive_bytes(0, frame.size() - 1, 0, -1);
    check_load("reload_after_reset", 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_basic();
    test_bad_checksum();
    test_too_long();
    test_zero_len();
    test_random_gaps();
    test_max_len();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
